// File: rtl/bcd_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among four requesters.
// One operand is outstanding at a time; a missing converter result is aborted after TIMEOUT cycles.
module bcd_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [127:0] req_data_i,
  input  logic [3:0]   req_valid_i,
  output logic [3:0]   req_ready_o,
  output logic [31:0]  cnv_data_o,
  output logic         cnv_valid_o,
  input  logic         cnv_ready_i,
  input  logic [39:0]  cnv_bcd_i,
  input  logic         cnv_bcd_valid_i,
  output logic         cnv_bcd_ready_o,
  output logic [39:0]  rsp_data_o,
  output logic [3:0]   rsp_valid_o,
  input  logic [3:0]   rsp_ready_i,
  output logic         rsp_err_o,
  output logic         busy_o
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [1:0]         last_grant_q;
  logic [TMR_W-1:0]   timer_q;
  logic [31:0]        op_p0;
  logic [1:0]         id_p0;
  logic [39:0]        res_p1;
  logic               err_p1;

  logic [2:0]         pick;
  logic               win_found;
  logic [1:0]         win_id;
  logic               accept;
  logic               res_take;
  logic               tmo_hit;

  // Upward search starting one past the previous winner; bit 2 flags a hit.
  function automatic logic [2:0] rr_pick(input logic [3:0] vld, input logic [1:0] last);
    logic [2:0] found;
    logic [1:0] idx;
    found = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found[2] && vld[idx]) begin
        found = {1'b1, idx};
      end
    end
    return found;
  endfunction

  assign pick      = rr_pick(req_valid_i, last_grant_q);
  assign win_found = pick[2];
  assign win_id    = pick[1:0];
  assign accept    = (state_q == S_IDLE) && win_found;
  assign res_take  = (state_q == S_WAIT) && cnv_bcd_valid_i;
  assign tmo_hit   = (state_q == S_WAIT) && !cnv_bcd_valid_i && (timer_q == TMR_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (win_found)          state_d = S_ISSUE;
      S_ISSUE:   if (cnv_ready_i)        state_d = S_WAIT;
      S_WAIT:    if (res_take || tmo_hit) state_d = S_DELIVER;
      S_DELIVER: if (rsp_ready_i[id_p0]) state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // p0: operand capture on accept
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_grant_q <= 2'd3;
      op_p0        <= '0;
      id_p0        <= '0;
    end else if (accept) begin
      last_grant_q <= win_id;
      op_p0        <= req_data_i[32*win_id +: 32];
      id_p0        <= win_id;
    end
  end

  // p1: result capture or timeout abort; timer is held at 0 outside WAIT
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      timer_q <= '0;
      res_p1  <= '0;
      err_p1  <= 1'b0;
    end else begin
      if (state_q == S_WAIT) begin
        timer_q <= timer_q + 1'b1;
      end else begin
        timer_q <= '0;
      end
      if (res_take) begin
        res_p1 <= cnv_bcd_i;
        err_p1 <= 1'b0;
      end else if (tmo_hit) begin
        res_p1 <= '0;
        err_p1 <= 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o     = '0;
    cnv_valid_o     = 1'b0;
    cnv_data_o      = '0;
    cnv_bcd_ready_o = 1'b0;
    rsp_valid_o     = '0;
    rsp_data_o      = '0;
    rsp_err_o       = 1'b0;
    busy_o          = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        // req_valid_i is live during reset, so the grant is masked explicitly
        if (rstn_i && win_found) begin
          req_ready_o[win_id] = 1'b1;
        end
      end
      S_ISSUE: begin
        cnv_valid_o = 1'b1;
        cnv_data_o  = op_p0;
      end
      S_WAIT: begin
        cnv_bcd_ready_o = 1'b1;
      end
      S_DELIVER: begin
        rsp_valid_o[id_p0] = 1'b1;
        rsp_data_o         = res_p1;
        rsp_err_o          = err_p1;
      end
      default: begin
        busy_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_arbiter.sv
// Bench for bcd_arbiter: directed transactions, a behavioural converter, and a
// per-cycle transaction-level model comparing every output on each falling edge.
module tb_bcd_arbiter;

  localparam int TIMEOUT = 64;

  logic         clk_i;
  logic         rstn_i;
  logic [127:0] req_data_i;
  logic [3:0]   req_valid_i;
  logic [3:0]   req_ready_o;
  logic [31:0]  cnv_data_o;
  logic         cnv_valid_o;
  logic         cnv_ready_i;
  logic [39:0]  cnv_bcd_i;
  logic         cnv_bcd_valid_i;
  logic         cnv_bcd_ready_o;
  logic [39:0]  rsp_data_o;
  logic [3:0]   rsp_valid_o;
  logic [3:0]   rsp_ready_i;
  logic         rsp_err_o;
  logic         busy_o;

  int tests = 0;
  int fails = 0;

  int cnv_lat  = 0;
  bit cnv_dead = 0;

  bcd_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .req_data_i      (req_data_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .cnv_data_o      (cnv_data_o),
    .cnv_valid_o     (cnv_valid_o),
    .cnv_ready_i     (cnv_ready_i),
    .cnv_bcd_i       (cnv_bcd_i),
    .cnv_bcd_valid_i (cnv_bcd_valid_i),
    .cnv_bcd_ready_o (cnv_bcd_ready_o),
    .rsp_data_o      (rsp_data_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_err_o       (rsp_err_o),
    .busy_o          (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] bcd(input logic [31:0] v);
    longint     x;
    logic [39:0] r;
    x = longint'(v);
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Converter: accepts the operand on handshake, answers after cnv_lat cycles unless dead.
  initial begin
    logic [31:0] pend;
    cnv_bcd_valid_i = 1'b0;
    cnv_bcd_i       = '0;
    forever begin
      @(negedge clk_i);
      if (rstn_i && cnv_valid_o && cnv_ready_i) begin
        pend = cnv_data_o;
        @(posedge clk_i);
        if (!cnv_dead) begin
          repeat (cnv_lat) @(posedge clk_i);
          #1;
          cnv_bcd_i       = bcd(pend);
          cnv_bcd_valid_i = 1'b1;
          @(negedge clk_i);
          @(posedge clk_i);
          #1;
          cnv_bcd_valid_i = 1'b0;
          cnv_bcd_i       = '0;
        end
      end
    end
  end

  // Transaction model: phase 0 idle, 1 operand out, 2 awaiting result, 3 response out.
  initial begin
    int          ph;
    int          lg;
    int          mid;
    int          wcnt;
    int          w;
    logic [31:0] mop;
    logic [39:0] mres;
    logic        merr;
    ph = 0; lg = 3; mid = 0; wcnt = 0; mop = '0; mres = '0; merr = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        ph = 0;
        lg = 3;
        chk("m_rst_ctrl", {req_ready_o, cnv_valid_o, cnv_bcd_ready_o, rsp_valid_o, rsp_err_o, busy_o}, 64'd0);
        chk("m_rst_data", {cnv_data_o, rsp_data_o}, 64'd0);
      end else begin
        case (ph)
          0: begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
              if (w < 0 && req_valid_i[(lg + k) % 4]) w = (lg + k) % 4;
            end
            chk("m_req_ready", req_ready_o, (w < 0) ? 64'd0 : (64'd1 << w));
            chk("m_idle_busy", busy_o, 0);
            chk("m_idle_rsp", {rsp_valid_o, rsp_data_o, cnv_valid_o}, 0);
            if (w >= 0) begin
              mid = w;
              mop = req_data_i[32*w +: 32];
              lg  = w;
              ph  = 1;
            end
          end
          1: begin
            chk("m_issue_ctrl", {req_ready_o, cnv_valid_o, cnv_bcd_ready_o, rsp_valid_o, busy_o}, 64'b0000_1_0_0000_1);
            chk("m_issue_data", cnv_data_o, mop);
            chk("m_issue_rsp", rsp_data_o, 0);
            if (cnv_ready_i) begin
              ph   = 2;
              wcnt = 0;
            end
          end
          2: begin
            chk("m_wait_ctrl", {req_ready_o, cnv_valid_o, cnv_bcd_ready_o, rsp_valid_o, busy_o}, 64'b0000_0_1_0000_1);
            chk("m_wait_rsp", rsp_data_o, 0);
            if (cnv_bcd_valid_i) begin
              mres = bcd(mop);
              merr = 1'b0;
              ph   = 3;
            end else if (wcnt == TIMEOUT - 1) begin
              mres = '0;
              merr = 1'b1;
              ph   = 3;
            end else begin
              wcnt++;
            end
          end
          default: begin
            chk("m_dlv_valid", rsp_valid_o, 64'd1 << mid);
            chk("m_dlv_data", rsp_data_o, mres);
            chk("m_dlv_err", rsp_err_o, merr);
            chk("m_dlv_ctrl", {req_ready_o, cnv_valid_o, cnv_bcd_ready_o, busy_o}, 64'b0000_0_0_1);
            if (rsp_ready_i[mid]) ph = 0;
          end
        endcase
      end
    end
  end

  task automatic wait_grant(input int id);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!req_ready_o[id] && n < 200);
    chk("grant_wait", (n < 200), 1);
  endtask

  task automatic issue(input int id, input logic [31:0] op);
    @(posedge clk_i);
    #1;
    req_data_i[32*id +: 32] = op;
    req_valid_i[id] = 1'b1;
    wait_grant(id);
    chk("grant_onehot", req_ready_o, 64'd1 << id);
    @(posedge clk_i);
    #1;
    req_valid_i[id] = 1'b0;
  endtask

  task automatic wait_rsp(output logic [3:0] v, output logic [39:0] d, output logic e, output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (rsp_valid_o == 4'b0000 && n < 400);
    chk("rsp_wait", (n < 400), 1);
    v = rsp_valid_o;
    d = rsp_data_o;
    e = rsp_err_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  v;
    logic [39:0] d;
    logic        e;
    int          n;
    int          grants [5];

    rstn_i      = 1'b0;
    req_data_i  = '0;
    req_valid_i = 4'hF;
    cnv_ready_i = 1'b1;
    rsp_ready_i = 4'hF;

    // Reset: no grant even with every request pending
    repeat (2) @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 4'b0000);
    chk("rst_busy", busy_o, 0);
    @(posedge clk_i);
    #1;
    req_valid_i = 4'h0;
    rstn_i      = 1'b1;

    // Fairness: all four pending continuously
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) req_data_i[32*i +: 32] = 32'(1000 + i);
    req_valid_i = 4'hF;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin
        @(negedge clk_i);
        n++;
      end while (req_ready_o == 4'b0000 && n < 100);
      chk("fair_wait", (n < 100), 1);
      grants[g] = -1;
      for (int k = 0; k < 4; k++) if (req_ready_o[k]) grants[g] = k;
      @(posedge clk_i);
    end
    #1;
    req_valid_i = 4'h0;
    wait_rsp(v, d, e, n);
    chk("fair_g0", grants[0], 0);
    chk("fair_g1", grants[1], 1);
    chk("fair_g2", grants[2], 2);
    chk("fair_g3", grants[3], 3);
    chk("fair_g4", grants[4], 0);
    for (int s = 0; s < 2; s++) begin
      int dup;
      dup = 0;
      for (int a = s; a < s + 4; a++)
        for (int b = a + 1; b < s + 4; b++)
          if (grants[a] == grants[b]) dup = 1;
      chk("fair_window", dup, 0);
    end

    // Single request, minimum latency
    cnv_lat = 0;
    issue(0, 32'd12345678);
    @(negedge clk_i);
    chk("single_cnv_valid", cnv_valid_o, 1);
    chk("single_cnv_data", cnv_data_o, 32'd12345678);
    wait_rsp(v, d, e, n);
    chk("single_latency", n, 2);
    chk("single_rsp_valid", v, 4'b0001);
    chk("single_rsp_data", d, 40'h0012345678);
    chk("single_rsp_err", e, 0);

    // Maximum operand from requester 2 with a slower converter
    cnv_lat = 3;
    issue(2, 32'hFFFFFFFF);
    wait_rsp(v, d, e, n);
    chk("max_rsp_valid", v, 4'b0100);
    chk("max_rsp_data", d, 40'h4294967295);
    chk("max_rsp_err", e, 0);

    // Timeout: converter never answers
    cnv_lat  = 0;
    cnv_dead = 1'b1;
    issue(1, 32'd5);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!cnv_bcd_ready_o && n < 50);
    chk("tmo_wait_entry", (n < 50), 1);
    n = 1;
    forever begin
      @(negedge clk_i);
      if (rsp_valid_o != 4'b0000 || n >= 200) break;
      n++;
    end
    chk("tmo_cycles", n, 64);
    chk("tmo_rsp_valid", rsp_valid_o, 4'b0010);
    chk("tmo_rsp_data", rsp_data_o, 40'h0);
    chk("tmo_rsp_err", rsp_err_o, 1);
    cnv_dead = 1'b0;
    issue(3, 32'd99);
    wait_rsp(v, d, e, n);
    chk("post_tmo_valid", v, 4'b1000);
    chk("post_tmo_data", d, 40'h0000000099);
    chk("post_tmo_err", e, 0);

    // Backpressure on both sides; requester 0 waits meanwhile
    cnv_ready_i = 1'b0;
    rsp_ready_i = 4'b1101;
    issue(1, 32'd777);
    req_data_i[31:0] = 32'd42;
    req_valid_i[0]   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      chk("bp_cnv_valid", cnv_valid_o, 1);
      chk("bp_cnv_data", cnv_data_o, 32'd777);
      chk("bp_no_grant", req_ready_o, 4'b0000);
    end
    @(posedge clk_i);
    #1;
    cnv_ready_i = 1'b1;
    wait_rsp(v, d, e, n);
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", rsp_valid_o, 4'b0010);
      chk("bp_rsp_data", rsp_data_o, 40'h0000000777);
      chk("bp_no_grant2", req_ready_o, 4'b0000);
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1;
    rsp_ready_i = 4'hF;
    wait_grant(0);
    @(posedge clk_i);
    #1;
    req_valid_i[0] = 1'b0;
    wait_rsp(v, d, e, n);
    chk("bp_next_valid", v, 4'b0001);
    chk("bp_next_data", d, 40'h0000000042);

    // Reset during WAIT discards the transaction
    cnv_dead = 1'b1;
    issue(2, 32'd31337);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!cnv_bcd_ready_o && n < 50);
    chk("rw_wait_entry", (n < 50), 1);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #2;
    rstn_i             = 1'b0;
    req_data_i[31:0]   = 32'd2468;
    req_data_i[127:96] = 32'd1357;
    req_valid_i        = 4'b1001;
    #1;
    chk("rw_async_ctrl", {req_ready_o, cnv_valid_o, cnv_bcd_ready_o, rsp_valid_o, rsp_err_o, busy_o}, 64'd0);
    chk("rw_async_data", {cnv_data_o, rsp_data_o}, 64'd0);
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    rstn_i   = 1'b1;
    cnv_dead = 1'b0;
    @(negedge clk_i);
    chk("rw_first_grant", req_ready_o, 4'b0001);
    @(posedge clk_i);
    #1;
    req_valid_i = 4'b0000;
    wait_rsp(v, d, e, n);
    chk("rw_rsp_valid", v, 4'b0001);
    chk("rw_rsp_data", d, 40'h0000002468);
    chk("rw_rsp_err", e, 0);

    repeat (5) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_arbiter.md
BCD_ARBITER -- requirements
Module: bcd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles allowed for a converter result before abort.
REQ-002 SHALL have port clk_i, input, 1, the single system clock.
REQ-003 SHALL have port rstn_i, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port req_data_i, input, 128, four 32-bit binary operands; requester n uses bits [32n+31:32n].
REQ-005 SHALL have port req_valid_i, input, 4, per-requester operand valid.
REQ-006 SHALL have port req_ready_o, output, 4, one-hot operand accept.
REQ-007 SHALL have port cnv_data_o, output, 32, operand to the shared BCD converter.
REQ-008 SHALL have port cnv_valid_o, output, 1, operand valid to the converter.
REQ-009 SHALL have port cnv_ready_i, input, 1, converter ready for an operand.
REQ-010 SHALL have port cnv_bcd_i, input, 40, converted 10-digit BCD result.
REQ-011 SHALL have port cnv_bcd_valid_i, input, 1, converter result valid.
REQ-012 SHALL have port cnv_bcd_ready_o, output, 1, result accept to the converter.
REQ-013 SHALL have port rsp_data_o, output, 40, shared BCD response bus.
REQ-014 SHALL have port rsp_valid_o, output, 4, one-hot response valid, addressed to the owning requester.
REQ-015 SHALL have port rsp_ready_i, input, 4, per-requester response accept.
REQ-016 SHALL have port rsp_err_o, output, 1, the current response is a timeout abort.
REQ-017 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-018 SHALL implement four states: IDLE, ISSUE, WAIT and DELIVER.
REQ-019 IDLE SHALL choose a requester by round-robin among the asserted req_valid_i bits, searching upward from last_grant+1 mod 4.
REQ-020 In IDLE, req_ready_o SHALL be combinationally one-hot on the winner, and SHALL be 0 when no request is pending or in any other state.
REQ-021 On the accept cycle, the block SHALL register the winner's operand and 2-bit ID, update last_grant to that ID, and go to ISSUE on the next edge.
REQ-022 ISSUE SHALL drive cnv_valid_o=1 and cnv_data_o=registered operand, holding both stable until cnv_ready_i=1 on a clock edge, then go to WAIT.
REQ-023 WAIT SHALL drive cnv_bcd_ready_o=1 and increment a timer that was cleared on entry.
REQ-024 In WAIT, cnv_bcd_valid_i=1 SHALL register cnv_bcd_i, clear the error flag and go to DELIVER.
REQ-025 If the timer reaches TIMEOUT-1 with cnv_bcd_valid_i=0, the block SHALL register a result of 40'h0, set the error flag and go to DELIVER.
REQ-026 If the result arrives on the timeout cycle, the result SHALL win and the error flag SHALL stay 0.
REQ-027 DELIVER SHALL assert rsp_valid_o only on the registered ID bit, drive rsp_data_o and rsp_err_o from registers, and hold them until rsp_ready_i[ID]=1.
REQ-028 DELIVER SHALL then return to IDLE; rsp_ready_i bits of other requesters SHALL be ignored.
REQ-029 Only one operand SHALL be outstanding at the converter at any time.
REQ-030 Minimum latency SHALL be 1 cycle accept-to-ISSUE, plus converter latency, plus 1 cycle result-to-DELIVER; IDLE SHALL be re-entered the cycle after the response is accepted.
REQ-031 req_valid_i changes outside the accept cycle SHALL have no effect; a requester whose valid drops before grant SHALL be skipped.
REQ-032 rsp_data_o SHALL be 0 outside DELIVER.

Reset
REQ-033 rstn_i low SHALL immediately force state=IDLE, last_grant=3 (requester 0 first), timer=0, and operand, ID, result and error registers all 0.
REQ-034 During reset, all outputs SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL discard that transaction with no response.

Verification
REQ-036 Single request: req_valid_i=4'b0001, operand 32'd12345678 -> req_ready_o=4'b0001; cnv_data_o=32'd12345678; rsp_valid_o=4'b0001; rsp_data_o=40'h0012345678; rsp_err_o=0.
REQ-037 Fairness: all four valid continuously with converter responsive -> grant order 0,1,2,3,0; no requester granted twice in any window of four.
REQ-038 Max value: requester 2 sends 32'hFFFFFFFF -> rsp_valid_o=4'b0100, rsp_data_o=40'h4294967295.
REQ-039 Timeout: converter never asserts result valid, TIMEOUT=64 -> DELIVER exactly 64 cycles after WAIT entry, with rsp_data_o=0 and rsp_err_o=1; the next transaction completes without error.
REQ-040 Backpressure: cnv_ready_i held low 10 cycles, and rsp_ready_i[1] held low 5 cycles in DELIVER -> cnv_data_o, rsp_data_o and rsp_valid_o stay stable throughout, and no new grant is issued.
REQ-041 Reset in WAIT: rstn_i pulsed low -> all outputs 0 asynchronously; after release, requester 0 wins against requesters 0 and 3 both valid.
